// File: rtl/scalar_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : scalar_wb_arbiter                                           |
// | Description : Writeback arbiter for the scalar register file. Merges ALU  |
// |               results and buffered load returns into one registered      |
// |               write port and tracks in-flight writes in a busy           |
// |               scoreboard.                                                |
// | Options     : SCALAR_WB_FWD_EN adds a write-port forwarding tap          |
// |               (rd_addr_1/2 -> fwd_hit_1/2, fwd_data).                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module scalar_wb_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int LQ_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_dst,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_dst,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   ld_ready,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_dst,
  output logic [(2**ADDR_W)-1:0] busy,
  output logic [2:0]             lq_count,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_dst,
  output logic [DATA_W-1:0]      wr_data
`ifdef SCALAR_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]      rd_addr_1,
  input  logic [ADDR_W-1:0]      rd_addr_2,
  output logic                   fwd_hit_1,
  output logic                   fwd_hit_2,
  output logic [DATA_W-1:0]      fwd_data
`endif
);

  // Storage is sized for the largest legal depth so a 2-bit pointer always
  // indexes it exactly; only the first LQ_DEPTH slots are ever used.
  localparam int       LQ_SLOTS = 4;
  localparam logic [2:0] C_DEPTH  = 3'(LQ_DEPTH);
  localparam logic [1:0] C_PTR_LAST = 2'(LQ_DEPTH - 1);

  logic [ADDR_W-1:0]      lq_dst  [LQ_SLOTS];
  logic [DATA_W-1:0]      lq_data [LQ_SLOTS];
  logic [1:0]             wr_ptr;
  logic [1:0]             rd_ptr;

  logic                   lq_full;
  logic                   lq_empty;
  logic                   push;
  logic                   sel_ld;
  logic                   sel_alu;
  logic                   sel_any;
  logic [ADDR_W-1:0]      sel_dst;
  logic [DATA_W-1:0]      sel_data;
  logic [(2**ADDR_W)-1:0] busy_nxt;

  assign lq_full   = (lq_count == C_DEPTH);
  assign lq_empty  = (lq_count == 3'd0);
  assign alu_ready = (lq_count != C_DEPTH);
  assign ld_ready  = (lq_count <  C_DEPTH);
  assign push      = ld_valid & ld_ready;

  // Arbitration: a full queue forces a drain, otherwise the ALU has priority.
  always_comb begin
    sel_ld   = lq_full | (~alu_valid & ~lq_empty);
    sel_alu  = ~lq_full & alu_valid;
    sel_any  = sel_ld | sel_alu;
    sel_dst  = sel_ld ? lq_dst[rd_ptr]  : alu_dst;
    sel_data = sel_ld ? lq_data[rd_ptr] : alu_data;
  end

  // Queue payload; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_dst[wr_ptr]  <= ld_dst;
      lq_data[wr_ptr] <= ld_data;
    end
  end

  // Queue pointers and occupancy; enqueue and pop together keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      lq_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == C_PTR_LAST) ? 2'd0 : wr_ptr + 2'd1;
      if (sel_ld) rd_ptr <= (rd_ptr == C_PTR_LAST) ? 2'd0 : rd_ptr + 2'd1;
      case ({push, sel_ld})
        2'b10:   lq_count <= lq_count + 3'd1;
        2'b01:   lq_count <= lq_count - 3'd1;
        default: lq_count <= lq_count;
      endcase
    end
  end

  // Scoreboard update: a retiring write clears, a new issue sets and wins.
  always_comb begin
    busy_nxt = busy;
    if (sel_any) busy_nxt[sel_dst] = 1'b0;
    if (iss_en)  busy_nxt[iss_dst] = 1'b1;
  end

  // Registered write port and scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_dst  <= '0;
      wr_data <= '0;
      busy    <= '0;
    end else begin
      wr_en <= sel_any;
      if (sel_any) begin
        wr_dst  <= sel_dst;
        wr_data <= sel_data;
      end
      busy <= busy_nxt;
    end
  end

`ifdef SCALAR_WB_FWD_EN
  // Forwarding tap covering the register file's read-before-write.
  assign fwd_hit_1 = wr_en & (wr_dst == rd_addr_1);
  assign fwd_hit_2 = wr_en & (wr_dst == rd_addr_2);
  assign fwd_data  = wr_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scalar_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_scalar_wb_arbiter                                        |
// | Description : Directed self-checking bench for scalar_wb_arbiter.         |
// |               Forwarding checks are included when SCALAR_WB_FWD_EN is    |
// |               defined.                                                   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_scalar_wb_arbiter;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int LQ_DEPTH = 2;

  logic              clk;
  logic              rst_n;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_dst;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_dst;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_dst;
  logic [15:0]       busy;
  logic [2:0]        lq_count;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_dst;
  logic [DATA_W-1:0] wr_data;
`ifdef SCALAR_WB_FWD_EN
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic              fwd_hit_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data;
`endif

  int tests_run;
  int tests_failed;

  scalar_wb_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LQ_DEPTH (LQ_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_dst   (alu_dst),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .ld_valid  (ld_valid),
    .ld_dst    (ld_dst),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .iss_en    (iss_en),
    .iss_dst   (iss_dst),
    .busy      (busy),
    .lq_count  (lq_count),
    .wr_en     (wr_en),
    .wr_dst    (wr_dst),
    .wr_data   (wr_data)
`ifdef SCALAR_WB_FWD_EN
    ,
    .rd_addr_1 (rd_addr_1),
    .rd_addr_2 (rd_addr_2),
    .fwd_hit_1 (fwd_hit_1),
    .fwd_hit_2 (fwd_hit_2),
    .fwd_data  (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at the falling edge; one tick crosses one rising edge and
  // returns to the next falling edge, where registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_dst = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_dst  = '0; ld_data  = '0;
    iss_en    = 1'b0; iss_dst = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle_inputs();
`ifdef SCALAR_WB_FWD_EN
    rd_addr_1 = '0;
    rd_addr_2 = '0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_wr_en",    32'(wr_en),     32'h0);
    check("rst_wr_dst",   32'(wr_dst),    32'h0);
    check("rst_wr_data",  32'(wr_data),   32'h0);
    check("rst_busy",     32'(busy),      32'h0);
    check("rst_lq_count", 32'(lq_count),  32'h0);
    check("rst_alu_rdy",  32'(alu_ready), 32'h1);
    check("rst_ld_rdy",   32'(ld_ready),  32'h1);
    rst_n = 1'b1;
    tick();

    // ALU only, with busy[3] set by an earlier issue
    iss_en = 1'b1; iss_dst = 4'd3;
    tick();
    check("iss_set_b3", 32'(busy), 32'h0008);
    iss_en = 1'b0;
    alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'h1234;
    check("alu_ready_empty", 32'(alu_ready), 32'h1);
    tick();
    check("alu_wr_en",   32'(wr_en),   32'h1);
    check("alu_wr_dst",  32'(wr_dst),  32'h3);
    check("alu_wr_data", 32'(wr_data), 32'h1234);
    check("alu_busy_clr", 32'(busy),   32'h0);
    alu_valid = 1'b0;
    tick();
    check("alu_one_pulse", 32'(wr_en),   32'h0);
    check("alu_hold_dst",  32'(wr_dst),  32'h3);
    check("alu_hold_data", 32'(wr_data), 32'h1234);

    // Load only: two-cycle latency, no bypass
    ld_valid = 1'b1; ld_dst = 4'd7; ld_data = 16'hBEEF;
    tick();
    ld_valid = 1'b0;
    check("ld_no_bypass", 32'(wr_en),    32'h0);
    check("ld_count1",    32'(lq_count), 32'h1);
    tick();
    check("ld_wr_en",   32'(wr_en),    32'h1);
    check("ld_wr_dst",  32'(wr_dst),   32'h7);
    check("ld_wr_data", 32'(wr_data),  32'hBEEF);
    check("ld_count0",  32'(lq_count), 32'h0);
    tick();
    check("ld_one_pulse", 32'(wr_en), 32'h0);

    // Contention: ALU held valid, two loads arrive
    alu_valid = 1'b1; alu_dst = 4'd1; alu_data = 16'h1111;
    ld_valid  = 1'b1; ld_dst  = 4'd8; ld_data  = 16'hA0A0;
    tick();
    check("ct_alu1_data", 32'(wr_data),  32'h1111);
    check("ct_count1",    32'(lq_count), 32'h1);
    alu_dst = 4'd2; alu_data = 16'h2222;
    ld_dst  = 4'd9; ld_data  = 16'hA0A1;
    tick();
    ld_valid = 1'b0;
    check("ct_alu2_data", 32'(wr_data),   32'h2222);
    check("ct_count2",    32'(lq_count),  32'h2);
    check("ct_alu_stall", 32'(alu_ready), 32'h0);
    check("ct_ld_stall",  32'(ld_ready),  32'h0);
    alu_dst = 4'd4; alu_data = 16'h3333;
    tick();
    check("ct_pop1_en",   32'(wr_en),     32'h1);
    check("ct_pop1_dst",  32'(wr_dst),    32'h8);
    check("ct_pop1_data", 32'(wr_data),   32'hA0A0);
    check("ct_count_dn",  32'(lq_count),  32'h1);
    check("ct_alu_resume_rdy", 32'(alu_ready), 32'h1);
    tick();
    check("ct_alu3_dst",  32'(wr_dst),   32'h4);
    check("ct_alu3_data", 32'(wr_data),  32'h3333);
    check("ct_count_hold", 32'(lq_count), 32'h1);
    alu_valid = 1'b0;
    tick();
    check("ct_pop2_dst",  32'(wr_dst),   32'h9);
    check("ct_pop2_data", 32'(wr_data),  32'hA0A1);
    check("ct_count_end", 32'(lq_count), 32'h0);
    tick();
    check("ct_idle", 32'(wr_en), 32'h0);

    // Scoreboard race: set and clear of r5 at the same edge
    iss_en = 1'b1; iss_dst = 4'd5;
    tick();
    check("sb_set5", 32'(busy), 32'h0020);
    alu_valid = 1'b1; alu_dst = 4'd5; alu_data = 16'h5555;
    tick();
    check("sb_race_wr",  32'(wr_en), 32'h1);
    check("sb_race_set", 32'(busy),  32'h0020);
    iss_en = 1'b0;
    tick();
    check("sb_clear5", 32'(busy), 32'h0);
    alu_dst = 4'd2; alu_data = 16'h0002;
    tick();
    check("sb_clear_zero", 32'(busy), 32'h0);
    alu_valid = 1'b0;
    tick();

`ifdef SCALAR_WB_FWD_EN
    // Forwarding tap during the write cycle
    alu_valid = 1'b1; alu_dst = 4'd3; alu_data = 16'h00FF;
    rd_addr_1 = 4'd3; rd_addr_2 = 4'd4;
    tick();
    alu_valid = 1'b0;
    check("fwd_hit_1", 32'(fwd_hit_1), 32'h1);
    check("fwd_hit_2", 32'(fwd_hit_2), 32'h0);
    check("fwd_data",  32'(fwd_data),  32'h00FF);
    tick();
    check("fwd_hit_1_off", 32'(fwd_hit_1), 32'h0);
`endif

    // Reset mid-stream with two queued loads and a busy bit
    alu_valid = 1'b1; alu_dst = 4'd10; alu_data = 16'h0A0A;
    ld_valid  = 1'b1; ld_dst  = 4'd12; ld_data  = 16'hCCCC;
    iss_en    = 1'b1; iss_dst = 4'd12;
    tick();
    iss_en = 1'b0;
    ld_dst = 4'd13; ld_data = 16'hDDDD;
    tick();
    idle_inputs();
    check("mr_count_full", 32'(lq_count), 32'h2);
    check("mr_busy_set",   32'(busy),     32'h1000);
    rst_n = 1'b0;
    #1;
    check("mr_count",   32'(lq_count), 32'h0);
    check("mr_busy",    32'(busy),     32'h0);
    check("mr_wr_en",   32'(wr_en),    32'h0);
    check("mr_wr_data", 32'(wr_data),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_write", 32'(wr_en),    32'h0);
      check("mr_count_0",  32'(lq_count), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
